r_empty: RTL



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_ptr.sv | 38 +++
 rtl/r_empty.sv | 100 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async FIFO types and Gray-code helpers.
// Helpers work on a wide vector; callers zero-extend and slice.
package fifo_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int PTR_MAX_W  = 16;

  typedef logic [ADDR_W_DEF:0]  ptr_t;
  typedef logic [PTR_MAX_W-1:0] gvec_t;

  function automatic gvec_t bin2gray(input gvec_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gvec_t gray2bin(input gvec_t g);
    gvec_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ptr.sv
// Multi-flop synchronizer for a Gray pointer crossing clock domains.
// Ports: clk, rst (async high), d_in (async), q_out (synchronized).
module sync_ptr #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  // First flop samples the raw input directly: no logic ahead of it.
  always_comb begin
    sync_d[0] = d_in;
    for (int s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/r_empty.sv
// Async FIFO read side: read pointer, empty and almost_empty flags.
// Ports: clk, rst (async high), w_ptr (write Gray, unsynced), r_en;
//   outputs r_addr, r_ptr (Gray), empty, almost_empty,
//   underflow (sticky, only with R_UNDERFLOW_EN defined).
module r_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   w_ptr,
  input  logic              r_en,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W:0]   r_ptr,
  output logic              empty,
  output logic              almost_empty
`ifdef R_UNDERFLOW_EN
  ,output logic             underflow
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] w_gray_s;
  logic [ADDR_W:0] w_bin_s;
  logic [ADDR_W:0] r_bin_q, r_bin_d;
  logic [ADDR_W:0] r_ptr_q, r_ptr_d;
  logic [ADDR_W:0] occ;
  logic            empty_q, empty_d;
  logic            ae_q, ae_d;
  logic            rd_ok;
  gvec_t           gray_w, bin_w;
  logic            unused_hi;

  sync_ptr #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (w_ptr),
    .q_out (w_gray_s)
  );

  always_comb begin
    rd_ok   = r_en & ~empty_q;
    r_bin_d = r_bin_q + {{ADDR_W{1'b0}}, rd_ok};
    gray_w  = bin2gray(gvec_t'(r_bin_d));
    r_ptr_d = gray_w[ADDR_W:0];
    bin_w   = gray2bin(gvec_t'(w_gray_s));
    w_bin_s = bin_w[ADDR_W:0];
    // Modular difference keeps occupancy right across the lap wrap.
    occ     = w_bin_s - r_bin_d;
    empty_d = (r_ptr_d == w_gray_s);
    ae_d    = empty_d | (32'(occ) <= AE_THRESH);
  end

  assign unused_hi = ^{gray_w[PTR_MAX_W-1:PW], bin_w[PTR_MAX_W-1:PW]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin_q <= '0;
      r_ptr_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
    end else begin
      r_bin_q <= r_bin_d;
      r_ptr_q <= r_ptr_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
    end
  end

  assign r_addr       = r_bin_q[ADDR_W-1:0];
  assign r_ptr        = r_ptr_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;

`ifdef R_UNDERFLOW_EN
  logic uf_q, uf_d;

  always_comb begin
    uf_d = uf_q | (r_en & empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uf_q <= 1'b0;
    end else begin
      uf_q <= uf_d;
    end
  end

  assign underflow = uf_q;
`endif

endmodule
